// File: rtl/mod_reducer_if.sv
// mod_reducer_if: operand/result handshake bundle between the exponentiation sequencer and mod_reducer
interface mod_reducer_if #(parameter int PW = 12, parameter int NW = 6);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] product;
  logic [NW-1:0] modulus;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] remainder;
  logic          err;
  modport master (output in_valid, product, modulus, out_ready, input in_ready, out_valid, remainder, err);
  modport slave (input in_valid, product, modulus, out_ready, output in_ready, out_valid, remainder, err);
endinterface

// File: rtl/mod_reducer.sv
// mod_reducer: restoring shift-subtract product mod n, one product bit per clock
module mod_reducer #(
  parameter int PW = 12,
  parameter int NW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  mod_reducer_if.slave bus
);
  localparam int IW = $clog2(PW);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        st;
  logic [PW-1:0] p;
  logic [NW-1:0] n;
  logic [NW:0]   r, t, rn;
  logic [IW-1:0] idx;
  // r < n keeps t within NW+1 bits, so a single conditional subtract restores it
  always_comb begin
    t  = {r[NW-1:0], p[idx]};
    rn = (t >= {1'b0, n}) ? t - {1'b0, n} : t;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st            <= IDLE;
      p             <= '0;
      n             <= '0;
      r             <= '0;
      idx           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.remainder <= '0;
      bus.err       <= 1'b0;
    end else
      case (st)
        IDLE: if (bus.in_valid) begin
          p            <= bus.product;
          n            <= bus.modulus;
          r            <= '0;
          idx          <= IW'(PW - 1);
          bus.in_ready <= 1'b0;
          if (bus.modulus == '0) begin
            st            <= DONE;
            bus.out_valid <= 1'b1;
            bus.err       <= 1'b1;
            bus.remainder <= '0;
          end else st <= RUN;
        end
        RUN: begin
          r <= rn;
          if (idx == '0) begin
            st            <= DONE;
            bus.out_valid <= 1'b1;
            bus.remainder <= rn[NW-1:0];
            bus.err       <= 1'b0;
          end else idx <= idx - 1'b1;
        end
        DONE: if (bus.out_ready) begin
          st            <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_mod_reducer.sv
// tb_mod_reducer: vector table, corner sequences and randomized regression against a % reference
module tb_mod_reducer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mod_reducer_if #(.PW(12), .NW(6)) b ();
  mod_reducer #(.PW(12), .NW(6)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  typedef struct {
    logic [11:0] p;
    logic [5:0]  m;
    logic [5:0]  rem;
    logic        e;
    int          lat;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Runs one transaction from a negedge; returns the observed result and edges from accept to out_valid
  task automatic op(input logic [11:0] p, input logic [5:0] m, input int stall, input bit hold,
                    output logic [5:0] rem, output logic e, output int lat);
    int w;
    b.in_valid = 1'b1;
    b.product  = p;
    b.modulus  = m;
    w = 0;
    while (!b.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", w < 100, 1);
    @(posedge clk);
    @(negedge clk);
    b.in_valid = 1'b0;
    b.product  = 12'($urandom);
    b.modulus  = 6'($urandom);
    lat = 0;
    while (!b.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rem = b.remainder;
    e   = b.err;
    if (hold) begin
      b.in_valid = 1'b1;
      b.product  = 12'd999;
      b.modulus  = 6'd10;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", b.out_valid, 1);
      chk("stall_rem", b.remainder, rem);
      chk("stall_err", b.err, e);
      chk("stall_in_ready", b.in_ready, 0);
    end
    b.out_ready = 1'b1;
    @(negedge clk);
    b.out_ready = 1'b0;
    chk("post_hs_valid", b.out_valid, 0);
    chk("post_hs_in_ready", b.in_ready, 1);
  endtask
  initial begin
    logic [5:0] rem;
    logic e;
    int lat;
    logic [11:0] rp;
    logic [5:0] rm;
    b.in_valid = 1'b0;
    b.product = '0;
    b.modulus = '0;
    b.out_ready = 1'b0;
    tbl = '{
      '{12'd1665, 6'd61, 6'd18, 1'b0, 12},
      '{12'd4095, 6'd63, 6'd0,  1'b0, 12},
      '{12'd4095, 6'd62, 6'd3,  1'b0, 12},
      '{12'd5,    6'd61, 6'd5,  1'b0, 12},
      '{12'd100,  6'd0,  6'd0,  1'b1, 0},
      '{12'd100,  6'd7,  6'd2,  1'b0, 12},
      '{12'd0,    6'd13, 6'd0,  1'b0, 12},
      '{12'd77,   6'd1,  6'd0,  1'b0, 12},
      '{12'd4095, 6'd0,  6'd0,  1'b1, 0},
      '{12'd63,   6'd63, 6'd0,  1'b0, 12}
    };
    #12;
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_rem", b.remainder, 0);
    chk("rst_err", b.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      op(tbl[i].p, tbl[i].m, 0, 1'b0, rem, e, lat);
      chk($sformatf("vec%0d_rem", i), rem, tbl[i].rem);
      chk($sformatf("vec%0d_err", i), e, tbl[i].e);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end
    op(12'd4095, 6'd62, 5, 1'b1, rem, e, lat);
    chk("bp_rem", rem, 3);
    chk("bp_err", e, 0);
    op(12'd999, 6'd10, 0, 1'b0, rem, e, lat);
    chk("bp_next_rem", rem, 9);
    chk("bp_next_lat", lat, 12);
    b.in_valid = 1'b1;
    b.product  = 12'd1665;
    b.modulus  = 6'd61;
    @(posedge clk);
    @(negedge clk);
    b.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", b.in_ready, 1);
    chk("arst_out_valid", b.out_valid, 0);
    chk("arst_rem", b.remainder, 0);
    chk("arst_err", b.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_valid", b.out_valid, 0);
    op(12'd200, 6'd9, 0, 1'b0, rem, e, lat);
    chk("arst_next_rem", rem, 2);
    chk("arst_next_lat", lat, 12);
    for (int k = 0; k < 1000; k++) begin
      rp = 12'($urandom);
      rm = ($urandom_range(15) == 0) ? 6'd0 : 6'($urandom);
      repeat ($urandom_range(2)) @(negedge clk);
      op(rp, rm, $urandom_range(3), 1'b0, rem, e, lat);
      chk("rnd_err", e, rm == 0);
      chk("rnd_rem", rem, rm == 0 ? 0 : rp % rm);
      chk("rnd_lat", lat, rm == 0 ? 0 : 12);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
